control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Main decoder for the single-cycle MIPS-subset datapath. It maps the instruction opcode and funct fields to the datapath control signals and to a 6-bit ALU function code, with zero latency. It sits between instruction fetch and the register file / ALU / data memory muxes. A small clocked section records whether an unsupported instruction was ever decoded.

Parameters:
None; all encodings are fixed constants from the shared package.

Ports:
clk  in  1  system clock; used only by the sticky illegal flag
rst  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26]
funct  in  6  instr[5:0]; meaningful only when opcode=000000
RegDst  out  1  1 = write register rd, 0 = write register rt
RegWrite  out  1  register file write enable
ALUSrc  out  1  1 = ALU operand B is sign-extended immediate, 0 = rt
MemRead  out  1  data memory read enable
MemWrite  out  1  data memory write enable
MemtoReg  out  1  1 = writeback comes from memory, 0 = from ALU
ALUFunc  out  6  ALU operation code, using the MIPS funct encoding
illegal  out  1  combinational flag: current opcode/funct is unsupported
illegal_seen  out  1  registered sticky flag: an unsupported instruction has been decoded since reset

Behaviour:
- All outputs except illegal_seen are purely combinational with zero latency. They must be valid within the same delta/cycle as opcode and funct, with no dependence on clk or rst.
- R-type (opcode 000000) with a supported funct: RegDst=1, RegWrite=1, ALUSrc=0, MemRead=0, MemWrite=0, MemtoReg=0, ALUFunc=funct.
- Supported funct values: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
- R-type with any other funct is a NOP: all six control bits = 0, ALUFunc=100000, illegal=1.
- LW (100011): RegDst=0, RegWrite=1, ALUSrc=1, MemRead=1, MemWrite=0, MemtoReg=1, ALUFunc=100000.
- SW (101011): RegDst=0, RegWrite=0, ALUSrc=1, MemRead=0, MemWrite=1, MemtoReg=0, ALUFunc=100000.
- ADDI (001000): RegDst=0, RegWrite=1, ALUSrc=1, MemRead=0, MemWrite=0, MemtoReg=0, ALUFunc=100000.
- Any other opcode: all control bits = 0, ALUFunc=100000 (ADD default), illegal=1. This is NOP-safe: no register write and no memory access.
- For non-R-type opcodes, funct is ignored entirely. Outputs must be fully defined (no X) even when funct is X or Z.
- Decode is a full case with the default assignments applied first, so no latches are inferred.
- illegal=0 for every supported instruction.
- illegal_seen, on each rising edge of clk:
  - rst=1 sets it to 0, and reset takes priority over everything else.
  - Otherwise it becomes illegal_seen | illegal.
- Reset value: illegal_seen=0. Reset has no effect on the combinational outputs.
- rst asserted mid-operation clears illegal_seen on that edge only; the decode outputs continue to track their inputs.

Decomposition:
- Shared package (e.g. mips_pkg) holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_ADDI=001000;
  - funct/ALU constants F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR;
  - ALU_DEFAULT=F_ADD.
- The ALU and this block share the funct constants.
- No sub-module is needed. The decode is one combinational process (or function), plus one always block for illegal_seen.

Test Plan:
1. opcode=000000, funct stepping through 100000, 100010, 100100, 100101, 100110, 100111 -> RegDst=1, RegWrite=1, others 0, ALUFunc=funct, illegal=0, checked 1 ns after each change.
2. opcode=100011, funct=X -> 0,1,1,1,0,1 (in port order RegDst..MemtoReg), ALUFunc=100000, no X on any output. Then opcode=101011 -> 0,0,1,0,1,0, ALUFunc=100000.
3. opcode=001000, funct=X -> 0,1,1,0,0,0, ALUFunc=100000, illegal=0.
4. opcode=111111, funct=000000 -> all controls 0, ALUFunc=100000, illegal=1. Likewise opcode=000000, funct=000011 -> all controls 0, ALUFunc=100000, illegal=1.
5. Sticky flag sequence:
   - Hold rst=1 for 2 clocks -> illegal_seen=0.
   - Apply legal instructions for 3 clocks -> illegal_seen stays 0.
   - Apply one illegal opcode for 1 clock, then legal again -> illegal_seen=1 and stays 1.
   - Assert rst for 1 clock -> illegal_seen=0 on the next edge.
6. Illegal opcode presented while rst=1 on the same edge -> illegal_seen=0, because reset wins.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared MIPS-subset encodings: opcodes, funct/ALU codes and the decoded control bundle.
package control_unit_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FUNC_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNC_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] F_XOR = 6'b100110;
    localparam logic [FUNC_W-1:0] F_NOR = 6'b100111;

    localparam logic [FUNC_W-1:0] ALU_DEFAULT = F_ADD;

    typedef struct packed {
        logic              reg_dst;
        logic              reg_write;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic [FUNC_W-1:0] alu_func;
        logic              illegal;
    } ctrl_t;

    // All-zero controls with ADD: the NOP-safe decode for anything unsupported.
    localparam ctrl_t CTRL_NOP = '{
        reg_dst:    1'b0,
        reg_write:  1'b0,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_func:   ALU_DEFAULT,
        illegal:    1'b1
    };

    function automatic logic is_alu_funct(input logic [FUNC_W-1:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Zero-latency main decoder for the single-cycle MIPS-subset datapath,
// plus a sticky record of any unsupported instruction seen since reset.
module control_unit
    import control_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] funct,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic [FUNC_W-1:0] ALUFunc,
    output logic              illegal,
    output logic              illegal_seen
);

    ctrl_t ctrl_c;

    // funct is only inspected on the R-type arm, so X/Z there cannot leak out.
    always_comb begin
        ctrl_c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                if (is_alu_funct(funct)) begin
                    ctrl_c.reg_dst   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_func  = funct;
                    ctrl_c.illegal   = 1'b0;
                end
            end
            OP_LW: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.illegal    = 1'b0;
            end
            OP_SW: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.illegal   = 1'b0;
            end
            OP_ADDI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.illegal   = 1'b0;
            end
            default: ctrl_c = CTRL_NOP;
        endcase
    end

    assign RegDst   = ctrl_c.reg_dst;
    assign RegWrite = ctrl_c.reg_write;
    assign ALUSrc   = ctrl_c.alu_src;
    assign MemRead  = ctrl_c.mem_read;
    assign MemWrite = ctrl_c.mem_write;
    assign MemtoReg = ctrl_c.mem_to_reg;
    assign ALUFunc  = ctrl_c.alu_func;
    assign illegal  = ctrl_c.illegal;

    // Reset wins over a same-edge illegal decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | ctrl_c.illegal;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed + randomized bench for control_unit against a table-driven reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg;
    logic [5:0] ALUFunc;
    logic       illegal, illegal_seen;

    int total = 0;
    int bad   = 0;
    logic seen_model;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUFunc(ALUFunc), .illegal(illegal), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg,ALUFunc[5:0],illegal}
    function automatic logic [12:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] alu_ops [6];
        alu_ops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39};
        if (op == 6'd0) begin
            foreach (alu_ops[i])
                if (fn === alu_ops[i]) return {6'b110000, fn, 1'b0};
            return {6'b000000, 6'd32, 1'b1};
        end
        if (op == 6'd35) return {6'b011101, 6'd32, 1'b0};
        if (op == 6'd43) return {6'b001010, 6'd32, 1'b0};
        if (op == 6'd8)  return {6'b011000, 6'd32, 1'b0};
        return {6'b000000, 6'd32, 1'b1};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, ALUFunc, illegal};
    endfunction

    // Apply one instruction for one clock: check decode 1ns after change, sticky flag 1ns after edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic r);
        logic [12:0] exp;
        @(negedge clk);
        opcode = op;
        funct  = fn;
        rst    = r;
        #1;
        exp = ref_decode(op, fn);
        check({tag, ".decode"}, 32'(dut_vec()), 32'(exp));
        @(posedge clk);
        seen_model = r ? 1'b0 : (seen_model | exp[0]);
        #1;
        check({tag, ".seen"}, 32'(illegal_seen), 32'(seen_model));
    endtask

    initial begin
        logic [5:0] rops [6];
        logic [5:0] pick;
        logic [5:0] fn;
        logic       r;
        rops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39};
        seen_model = 1'b0;
        rst = 1'b1;
        opcode = 6'd0;
        funct  = 6'd32;

        // Reset held two clocks
        step("rst0", 6'd0, 6'd32, 1'b1);
        step("rst1", 6'd63, 6'd0, 1'b1);
        check("reset_seen", 32'(illegal_seen), 32'd0);

        // R-type supported functs
        foreach (rops[i]) step($sformatf("rtype%0d", i), 6'd0, rops[i], 1'b0);

        // Memory / immediate with funct X
        step("lw",   6'd35, 6'bx, 1'b0);
        check("lw_noX", 32'($isunknown(dut_vec())), 32'd0);
        step("sw",   6'd43, 6'bx, 1'b0);
        step("addi", 6'd8,  6'bx, 1'b0);
        check("addi_noX", 32'($isunknown(dut_vec())), 32'd0);

        // Sticky: still clear, then one illegal opcode, then legal again
        check("seen_before_illegal", 32'(illegal_seen), 32'd0);
        step("bad_op", 6'd63, 6'd0, 1'b0);
        step("legal_after", 6'd35, 6'd0, 1'b0);
        check("seen_sticky", 32'(illegal_seen), 32'd1);
        step("bad_funct", 6'd0, 6'd3, 1'b0);

        // Reset clears; reset beats a same-edge illegal
        step("rst_clear", 6'd8, 6'd0, 1'b1);
        check("seen_cleared", 32'(illegal_seen), 32'd0);
        step("rst_vs_illegal", 6'd63, 6'd0, 1'b1);
        check("reset_wins", 32'(illegal_seen), 32'd0);

        // Randomized: mix of legal encodings, arbitrary opcodes/functs, sparse resets
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: pick = 6'd0;
                1: pick = 6'd35;
                2: pick = 6'd43;
                3: pick = 6'd8;
                default: pick = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 2) == 0) ? 6'($urandom) : rops[$urandom_range(0, 5)];
            r  = ($urandom_range(0, 19) == 0);
            step($sformatf("rnd%0d", n), pick, fn, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
